// File: rtl/auto_player_seq_if.sv
// Control, song-memory and buzzer signals of the auto-play sequencer.
// TEMPO_SCALE_EN adds the tempo_shift control input.
interface auto_player_seq_if #(
  parameter int unsigned NOTE_W = 4,
  parameter int unsigned DUR_W  = 28,
  parameter int unsigned ADDR_W = 5
);
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_mode;
  logic [NOTE_W-1:0] mem_note;
  logic [DUR_W-1:0]  mem_dur;
  logic [ADDR_W-1:0] mem_addr;
  logic              key_on;
  logic [NOTE_W-1:0] key;
  logic              playing;
  logic              song_done;
`ifdef TEMPO_SCALE_EN
  logic [1:0]        tempo_shift;
`endif

  // Sequencer side: reads control and song data, drives address and buzzer.
  modport master (
    input  start, stop, pause, loop_mode, mem_note, mem_dur,
`ifdef TEMPO_SCALE_EN
    input  tempo_shift,
`endif
    output mem_addr, key_on, key, playing, song_done
  );

  // Environment side: controller, song ROM and buzzer.
  modport slave (
    output start, stop, pause, loop_mode, mem_note, mem_dur,
`ifdef TEMPO_SCALE_EN
    output tempo_shift,
`endif
    input  mem_addr, key_on, key, playing, song_done
  );
endinterface

// File: rtl/auto_player_seq.sv
// Auto-play sequencer: walks note/duration entries of a song ROM and drives the buzzer key.
// Optional TEMPO_SCALE_EN: effective duration = mem_dur >> tempo_shift (minimum 1).
module auto_player_seq #(
  parameter int unsigned NOTE_W     = 4,
  parameter int unsigned DUR_W      = 28,
  parameter int unsigned SONG_LEN   = 25,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned GAP_CYCLES = 50000000
) (
  input logic              clk,
  input logic              rst,
  auto_player_seq_if.master bus_io
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StNote, StGap} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [NOTE_W-1:0] key_q, key_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gcnt_q, gcnt_d;
  logic [DUR_W-1:0]  eff_dur;
  logic              advance;
  logic              end_song;
  logic              song_done;

  always_comb begin
`ifdef TEMPO_SCALE_EN
    eff_dur = bus_io.mem_dur >> bus_io.tempo_shift;
    if (eff_dur == '0) eff_dur = DUR_W'(1);
`else
    eff_dur = bus_io.mem_dur;
`endif
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    key_d     = key_q;
    dur_d     = dur_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    advance   = 1'b0;
    end_song  = 1'b0;
    song_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          addr_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: state_d = StLoad;
      StLoad: begin
        // End marker is judged on the raw duration, before any tempo scaling.
        if (bus_io.mem_dur == '0) begin
          end_song = 1'b1;
        end else begin
          key_d   = bus_io.mem_note;
          dur_d   = eff_dur;
          cnt_d   = DUR_W'(1);
          state_d = StNote;
        end
      end
      StNote: begin
        // Compare before increment so an all-ones duration never wraps.
        if (!bus_io.pause) begin
          if (cnt_q == dur_q) begin
            if (GAP_CYCLES == 0) begin
              advance = 1'b1;
            end else begin
              gcnt_d  = GAP_W'(1);
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + DUR_W'(1);
          end
        end
      end
      StGap: begin
        if (!bus_io.pause) begin
          if (gcnt_q == GAP_W'(GAP_CYCLES)) advance = 1'b1;
          else                              gcnt_d  = gcnt_q + GAP_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    if (advance) begin
      if (addr_q < ADDR_W'(SONG_LEN - 1)) begin
        addr_d  = addr_q + ADDR_W'(1);
        state_d = StFetch;
      end else begin
        end_song = 1'b1;
      end
    end

    if (end_song) begin
      addr_d = '0;
      if (bus_io.loop_mode) begin
        state_d = StFetch;
      end else begin
        song_done = 1'b1;
        key_d     = '0;
        state_d   = StIdle;
      end
    end

    // Stop overrides everything, including a same-cycle start or song end.
    if (bus_io.stop) begin
      state_d   = StIdle;
      key_d     = '0;
      addr_d    = '0;
      song_done = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      key_q   <= '0;
      dur_q   <= '0;
      cnt_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      key_q   <= key_d;
      dur_q   <= dur_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  // key_on follows state so an async reset silences the buzzer at once.
  assign bus_io.key_on    = (state_q == StNote) && !bus_io.pause;
  assign bus_io.key       = key_q;
  assign bus_io.mem_addr  = addr_q;
  assign bus_io.playing   = (state_q != StIdle);
  assign bus_io.song_done = song_done;

endmodule

// File: tb/tb_auto_player_seq.sv
// Randomised bench for auto_player_seq: a song-level model queues expected notes and done
// pulses; a negedge monitor measures notes, gaps and done pulses and checks them in order.
module tb_auto_player_seq;
  localparam int NOTE_W   = 4;
  localparam int DUR_W    = 8;
  localparam int SONG_LEN = 4;
  localparam int ADDR_W   = 2;
  localparam int GAP      = 3;

  typedef struct {
    bit is_done;
    int key;
    int len;
    int gap;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   rom_note[SONG_LEN];
  int   rom_dur[SONG_LEN];
  int   tempo = 0;
  bit   pause_en = 1'b0;
  ev_t  exp_q[$];
  ev_t  mon_e;
  int   hi = 0;
  int   lowc = 0;
  int   cur_key = 0;

  always #5 clk = ~clk;

  auto_player_seq_if #(.NOTE_W(NOTE_W), .DUR_W(DUR_W), .ADDR_W(ADDR_W)) bus ();

  auto_player_seq #(
    .NOTE_W(NOTE_W), .DUR_W(DUR_W), .SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus)
  );

  // Synchronous song ROM: data for an address appears the cycle after it is presented.
  always @(posedge clk) begin
    bus.mem_note <= NOTE_W'(rom_note[bus.mem_addr]);
    bus.mem_dur  <= DUR_W'(rom_dur[bus.mem_addr]);
  end

`ifdef TEMPO_SCALE_EN
  assign bus.tempo_shift = 2'(tempo);
`endif

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    total++;
    bad++;
    $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int eff(input int d);
`ifdef TEMPO_SCALE_EN
    int r;
    r = d >> tempo;
    if (r == 0) r = 1;
    return r;
`else
    return d;
`endif
  endfunction

  // Song-level model: each visited entry costs fetch+load (2 low cycles), each note is
  // followed by GAP low cycles. gap = low cycles seen before the note starts / done fires.
  task automatic model_play(input bit lp, input int max_notes);
    int  i = 0;
    int  acc = 0;
    int  n = 0;
    bit  fin = 1'b0;
    ev_t e;
    while (!fin) begin
      acc += 2;
      if (rom_dur[i] == 0) begin
        if (lp) begin
          i = 0;
        end else begin
          e.is_done = 1'b1; e.key = 0; e.len = 0; e.gap = acc;
          exp_q.push_back(e);
          fin = 1'b1;
        end
      end else if (lp && n == max_notes) begin
        fin = 1'b1;
      end else begin
        e.is_done = 1'b0; e.key = rom_note[i]; e.len = eff(rom_dur[i]); e.gap = acc;
        exp_q.push_back(e);
        n++;
        acc = GAP;
        i++;
        if (i == SONG_LEN) begin
          i = 0;
          if (!lp) begin
            e.is_done = 1'b1; e.key = 0; e.len = 0; e.gap = acc;
            exp_q.push_back(e);
            fin = 1'b1;
          end
        end
      end
    end
  endtask

  // Monitor: a note ends at the first unpaused cycle with key_on low after high cycles.
  always @(negedge clk) begin
    if (rst) begin
      hi   = 0;
      lowc = 0;
    end else begin
      if (!bus.playing) lowc = 0;
      if (bus.key_on) begin
        if (hi == 0) begin
          cur_key = int'(bus.key);
          if (exp_q.size() == 0 || exp_q[0].is_done) fail_now("unexpected_note", cur_key, -1);
          else chk("gap_before_note", lowc, exp_q[0].gap);
          lowc = 0;
        end
        hi++;
      end else begin
        if (!bus.pause && hi > 0) begin
          if (exp_q.size() == 0 || exp_q[0].is_done) begin
            fail_now("unexpected_note_end", hi, 0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("note_key", cur_key, mon_e.key);
            chk("note_len", hi, mon_e.len);
          end
          hi   = 0;
          lowc = 0;
        end
        if (bus.playing && !bus.pause) lowc++;
      end
      if (bus.song_done) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          fail_now("unexpected_song_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_gap", lowc, mon_e.gap);
          chk("done_key_on", int'(bus.key_on), 0);
        end
      end
    end
  end

  // Random pause bursts, only ever raised while a note is sounding.
  always begin
    @(posedge clk);
    #1;
    if (pause_en && bus.key_on && $urandom_range(0, 3) == 0) begin
      bus.pause = 1'b1;
      repeat ($urandom_range(1, 10)) @(posedge clk);
      #1;
      bus.pause = 1'b0;
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.stop = 1'b0;
  endtask

  task automatic wait_empty(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_expected", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_key_on(input int budget);
    int n = 0;
    while (!bus.key_on && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("key_on_seen", int'(bus.key_on), 1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_playing"}, int'(bus.playing), 0);
    chk({tag, "_mem_addr"}, int'(bus.mem_addr), 0);
    chk({tag, "_key"}, int'(bus.key), 0);
    chk({tag, "_key_on"}, int'(bus.key_on), 0);
  endtask

  task automatic set_spec_rom();
    rom_note[0] = 5; rom_dur[0] = 4;
    rom_note[1] = 7; rom_dur[1] = 2;
    rom_note[2] = 1; rom_dur[2] = 1;
    rom_note[3] = 3; rom_dur[3] = 6;
  endtask

  task automatic run(input bit lp, input int notes, input bit extra_start, input string tag);
    bus.loop_mode = lp;
    model_play(lp, notes);
    pulse_start();
    if (extra_start) begin
      repeat (5) @(posedge clk);
      #1;
      pulse_start();
    end
    wait_empty(4000);
    if (lp) pulse_stop();
    chk_idle(tag);
  endtask

  initial begin
    bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0; bus.loop_mode = 1'b0;
    set_spec_rom();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_song_done", int'(bus.song_done), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // One-shot spec song, with a start pulse mid-playback that must be ignored.
    run(1'b0, 0, 1'b1, "oneshot");
    // Loop mode: wraps and replays note 5 and 7, no done pulse.
    run(1'b1, 6, 1'b0, "loop");
    // End marker at entry 1.
    rom_dur[1] = 0;
    run(1'b0, 0, 1'b0, "marker");
    set_spec_rom();

    // Pause held 10 cycles from the second cycle of note 5; note still totals 4 high cycles.
    bus.loop_mode = 1'b0;
    model_play(1'b0, 0);
    pulse_start();
    wait_key_on(20);
    @(posedge clk); #1;
    bus.pause = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    bus.pause = 1'b0;
    wait_empty(4000);
    chk_idle("pause");

    // Stop during gap of entry 1: only notes 5 and 7 play, no done pulse.
    begin
      ev_t e;
      e.is_done = 1'b0; e.key = 5; e.len = eff(4); e.gap = 2;   exp_q.push_back(e);
      e.is_done = 1'b0; e.key = 7; e.len = eff(2); e.gap = GAP + 2; exp_q.push_back(e);
    end
    pulse_start();
    wait_empty(200);
    pulse_stop();
    chk_idle("stop");

    // Start and stop together from idle.
    bus.start = 1'b1; bus.stop = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.stop = 1'b0;
    chk_idle("start_stop");
    @(posedge clk); #1;
    chk("start_stop_still_idle", int'(bus.playing), 0);

    // Longest duration must complete without counter overflow.
    rom_note[0] = 9; rom_dur[0] = (1 << DUR_W) - 1;
    run(1'b0, 0, 1'b0, "maxdur");
    set_spec_rom();

`ifdef TEMPO_SCALE_EN
    tempo = 2;
    run(1'b0, 0, 1'b0, "tempo2");
    tempo = 0;
`endif

    // Async reset mid-note silences immediately.
    model_play(1'b0, 0);
    pulse_start();
    wait_key_on(20);
    @(negedge clk); #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk_idle("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomised songs, modes, pauses and tempo.
    for (int it = 0; it < 12; it++) begin
      bit lp;
      lp = 1'($urandom_range(0, 1));
      for (int i = 0; i < SONG_LEN; i++) begin
        rom_note[i] = $urandom_range(1, 15);
        rom_dur[i]  = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 8);
      end
      if (lp && rom_dur[0] == 0) rom_dur[0] = $urandom_range(1, 8);
`ifdef TEMPO_SCALE_EN
      tempo = $urandom_range(0, 3);
`endif
      pause_en = 1'($urandom_range(0, 1));
      run(lp, 5, 1'b0, "random");
      pause_en = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
